// File: rtl/gate_truth_checker_pkg.sv
// gates_pkg: shared FSM encodings and reference truth tables for the gate-conversion library
package gates_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [7:0] TT_PAR3  = 8'h96;
endpackage

// File: rtl/gate_truth_checker_if.sv
// gate_truth_checker_if: control, stimulus and result signals between a controller and the checker
interface gate_truth_checker_if #(parameter int N_IN = 2) ();
  logic            start;
  logic [N_IN-1:0] stim;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;
  modport master (output start, dut_y, input stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid);
  modport slave (input start, dut_y, output stim, busy, done, pass, err_count, first_fail_vec, first_fail_valid);
endinterface

// File: rtl/gate_truth_checker_settle_timer.sv
// settle_timer: clear/enable counter that ticks on the last cycle of each settle window
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(SETTLE + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(SETTLE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input vector into a gate under test and compares against a truth table
module gate_truth_checker
  import gates_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  EXPECT = TT_XOR2
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_truth_checker_if.slave bus
);
  state_t        state;
  logic          go, tick, mismatch, last;
  logic [N_IN:0] err_next;
  assign go       = state != DRIVE && bus.start;
  assign mismatch = bus.dut_y != EXPECT[bus.stim];
  assign last     = bus.stim == N_IN'(2**N_IN - 1);
  assign err_next = bus.err_count + (N_IN + 1)'(mismatch);
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (state == DRIVE),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state                <= IDLE;
      bus.stim             <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.pass             <= 1'b0;
      bus.err_count        <= '0;
      bus.first_fail_vec   <= '0;
      bus.first_fail_valid <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (go) begin
        state                <= DRIVE;
        bus.stim             <= '0;
        bus.busy             <= 1'b1;
        bus.pass             <= 1'b0;
        bus.err_count        <= '0;
        bus.first_fail_valid <= 1'b0;
      end else if (state == DRIVE && tick) begin
        bus.err_count <= err_next;
        if (mismatch && !bus.first_fail_valid) begin
          bus.first_fail_vec   <= bus.stim;
          bus.first_fail_valid <= 1'b1;
        end
        // stim returns to 0 only through the DONE transition, never by carry
        if (last) begin
          state    <= DONE;
          bus.stim <= '0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.pass <= err_next == '0;
        end else
          bus.stim <= bus.stim + N_IN'(1);
      end
    end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: scoreboard bench for a 2-input XOR sweep and a 3-input parity sweep
module tb_gate_truth_checker;
  import gates_pkg::*;
  typedef struct {
    int   err;
    logic ffv;
    int   ffvec;
    logic pass;
  } res_t;
  logic clk = 0, rst_n = 0, sel = 0;
  int   mode = 0, n_cmp = 0, n_err = 0;
  res_t rq[$];
  int   sq[$];
  always #5 clk = ~clk;
  gate_truth_checker_if #(.N_IN(2)) a_if ();
  gate_truth_checker_if #(.N_IN(3)) b_if ();
  gate_truth_checker u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  gate_truth_checker #(.N_IN(3), .SETTLE(1), .EXPECT(TT_PAR3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  logic n1, n2, n3, xr;
  assign n1 = ~(a_if.stim[1] & a_if.stim[0]);
  assign n2 = ~(a_if.stim[1] & n1);
  assign n3 = ~(a_if.stim[0] & n1);
  assign xr = ~(n2 & n3);
  assign a_if.dut_y = mode == 0 ? xr : mode == 1 ? 1'b0 : ~(a_if.stim[1] ^ a_if.stim[0]);
  assign b_if.dut_y = ^b_if.stim;
  logic       mon_busy, mon_done, mon_pass, mon_ffv;
  logic [3:0] mon_err;
  logic [2:0] mon_ffvec, mon_stim;
  assign mon_busy  = sel ? b_if.busy : a_if.busy;
  assign mon_done  = sel ? b_if.done : a_if.done;
  assign mon_pass  = sel ? b_if.pass : a_if.pass;
  assign mon_ffv   = sel ? b_if.first_fail_valid : a_if.first_fail_valid;
  assign mon_err   = sel ? b_if.err_count : {1'b0, a_if.err_count};
  assign mon_ffvec = sel ? b_if.first_fail_vec : {1'b0, a_if.first_fail_vec};
  assign mon_stim  = sel ? b_if.stim : {1'b0, a_if.stim};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic v);
    if (s) b_if.start = v;
    else a_if.start = v;
  endtask

  always @(negedge clk)
    if (rst_n && mon_busy) begin
      if (sq.size() == 0) check("stim_unexpected_busy", mon_busy, 0);
      else check("stim", mon_stim, sq.pop_front());
    end

  task automatic push_stim(input logic s);
    for (int v = 0; v < (s ? 8 : 4); v++)
      repeat (s ? 1 : 2) sq.push_back(v);
  endtask

  task automatic run(input logic s, input int m, input bit repulse);
    res_t r;
    int lat;
    logic [7:0] tt;
    logic y;
    sel = s;
    mode = m;
    tt = s ? TT_PAR3 : {4'h0, TT_XOR2};
    r = '{0, 1'b0, 0, 1'b1};
    for (int v = 0; v < (s ? 8 : 4); v++) begin
      y = m == 0 ? ^v[2:0] : m == 1 ? 1'b0 : ~^v[1:0];
      if (y != tt[v]) begin
        if (!r.ffv) begin
          r.ffv = 1'b1;
          r.ffvec = v;
        end
        r.err++;
      end
    end
    r.pass = r.err == 0;
    rq.push_back(r);
    push_stim(s);
    @(negedge clk) pulse(s, 1'b1);
    @(negedge clk) pulse(s, 1'b0);
    lat = 1;
    check("busy_start", mon_busy, 1);
    check("err_clr", mon_err, 0);
    check("ffv_clr", mon_ffv, 0);
    check("pass_clr", mon_pass, 0);
    while (!mon_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (repulse && lat == 4) pulse(s, 1'b1);
      if (repulse && lat == 5) pulse(s, 1'b0);
    end
    check("done_lat", lat, 9);
    r = rq.pop_front();
    check("err_count", mon_err, r.err);
    check("pass", mon_pass, r.pass);
    check("ffv", mon_ffv, r.ffv);
    if (r.ffv) check("ffvec", mon_ffvec, r.ffvec);
    check("busy_done", mon_busy, 0);
    check("stim_done", mon_stim, 0);
    check("stim_left", sq.size(), 0);
    @(negedge clk);
    check("done_pulse", mon_done, 0);
    check("err_hold", mon_err, r.err);
  endtask

  initial begin
    int lat;
    a_if.start = 0;
    b_if.start = 0;
    #1;
    check("rst_busy", a_if.busy, 0);
    check("rst_stim", a_if.stim, 0);
    check("rst_err", a_if.err_count, 0);
    check("rst_ffv", a_if.first_fail_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("idle_busy", a_if.busy, 0);
    run(0, 0, 0);
    run(0, 1, 0);
    run(0, 2, 0);
    run(0, 0, 1);
    sel = 0;
    mode = 2;
    push_stim(0);
    @(negedge clk) a_if.start = 1;
    @(negedge clk) a_if.start = 0;
    lat = 0;
    while (a_if.stim != 2'b10 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("reach_stim_10", a_if.stim, 2);
    #2 rst_n = 0;
    #1;
    sq.delete();
    check("arst_busy", a_if.busy, 0);
    check("arst_done", a_if.done, 0);
    check("arst_pass", a_if.pass, 0);
    check("arst_err", a_if.err_count, 0);
    check("arst_ffv", a_if.first_fail_valid, 0);
    check("arst_ffvec", a_if.first_fail_vec, 0);
    check("arst_stim", a_if.stim, 0);
    @(negedge clk) rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_rst", a_if.busy, 0);
      check("idle_stim", a_if.stim, 0);
    end
    run(0, 0, 0);
    run(1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
